writeback_queue: RTL and testbench
==================================

// Module: writeback_queue
// PURPOSE
//  Writeback buffer directly upstream of register_file. Accepts destination-register
//  writes from the execute/load path via valid/ready and holds them in a small in-order
//  FIFO. Drains one entry per cycle into the register file write port
//  (writeEn/writeAddr/writeData). Offers two combinational forwarding lookups so operand
//  reads observe writes that are still queued.
// PARAMETERS
//  DataWidth   32                   register data width
//  NumRegs     32                   architectural registers
//  IndexWidth  $clog2(NumRegs)      register index width
//  Depth       4                    FIFO entries; power of 2, >= 2
//  CountWidth  $clog2(Depth+1)      occupancy counter width
// PORTS
//  clk          in   1           clock, rising edge
//  reset        in   1           asynchronous, active-low reset
//  inValid      in   1           producer has a write request
//  inReady      out  1           queue can accept (not full)
//  inAddr       in   IndexWidth  destination register
//  inData       in   DataWidth   value to write
//  wbStall      in   1           1 = register file port unavailable, hold head
//  writeEn      out  1           to register_file.writeEn
//  writeAddr    out  IndexWidth  to register_file.writeAddr
//  writeData    out  DataWidth   to register_file.writeData
//  lookupAddr1  in   IndexWidth  forwarding query 1 (rs1)
//  lookupAddr2  in   IndexWidth  forwarding query 2 (rs2)
//  lookupHit1   out  1           queued write to lookupAddr1 exists
//  lookupHit2   out  1           queued write to lookupAddr2 exists
//  lookupData1  out  DataWidth   youngest queued value for lookupAddr1
//  lookupData2  out  DataWidth   youngest queued value for lookupAddr2
//  count        out  CountWidth  current occupancy
// BEHAVIOUR
//  - Reset (reset=0, async): head/tail pointers, count and all entry-valid bits cleared;
//    queued entries discarded, including mid-drain. While count=0 and reset is low:
//    inReady=1, writeEn=0, writeAddr=0, writeData=0, lookupHit*=0, lookupData*=0, count=0.
//  - inReady = (count < Depth), combinational from count only. When full, a
//    same-cycle dequeue does NOT make inReady=1.
//  - Enqueue: on a rising edge with inValid && inReady && inAddr!=0, write
//    {inAddr,inData} at tail; tail advances mod Depth.
//  - Writes to x0: inAddr==0 with inValid && inReady is accepted and dropped.
//    No entry, count unchanged.
//  - Dequeue: when count>0 && !wbStall, writeEn=1 and writeAddr/writeData=head entry
//    (combinational). Head advances mod Depth on that edge. Otherwise writeEn=0,
//    writeAddr=0, writeData=0.
//  - Latency: accepted at edge N is eligible at head in cycle N+1. If the queue was
//    empty and wbStall=0, writeEn=1 in cycle N+1, and register_file commits at the end
//    of N+1.
//  - Ordering: strictly FIFO. Same register written twice drains in acceptance order.
//  - Simultaneous enqueue+dequeue (not full): both occur, count unchanged.
//    Enqueue when count=0 never bypasses to writeEn in the same cycle.
//  - Lookup (combinational): lookupHitK=1 if lookupAddrK!=0 and any valid entry,
//    including the head being drained this cycle, has addr==lookupAddrK.
//    lookupDataK = data of the youngest (closest to tail) match; 0 when no hit.
//    The current-cycle inValid request is never matched.
//  - Counter arithmetic: count in 0..Depth; never overflows (inReady gating) and never
//    underflows (dequeue requires count>0).
//  - Pointers are log2(Depth) bits, wrap naturally. No other state; no FSM beyond FIFO.
// TESTING
//  1 reset low at t=5 -> count=0, inReady=1, writeEn=0, lookupHit1/2=0; hold after release.
//  2 wbStall=0, push addr 5 data 32'h1234_5678 at edge N -> cycle N+1: writeEn=1,
//    writeAddr=5, writeData=32'h1234_5678; count=0 after edge N+1.
//  3 wbStall=1, push addr 1..4 data 'h11..'h44 -> count=4, inReady=0, 5th push
//    (addr 9) not accepted. Drop wbStall -> writeAddr 1,2,3,4 on 4 consecutive
//    cycles, inReady=1 after first pop, then writeEn=0.
//  4 wbStall=1, push addr 7 'hAAAA then addr 7 'hBBBB; lookupAddr1=7, lookupAddr2=8
//    -> lookupHit1=1, lookupData1='hBBBB, lookupHit2=0, lookupData2=0.
//  5 push addr 0 data 32'hdead_beef -> count stays 0, writeEn stays 0;
//    lookupAddr1=0 -> lookupHit1=0.
//  6 wbStall=1, 3 entries queued, pulse reset low mid-stream -> count=0 asynchronously;
//    after release and wbStall=0, writeEn never asserts.

Source files
------------

// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
//
// Purpose:
//   Small in-order writeback buffer that sits directly in front of the register
//   file write port. The execute/load path pushes destination-register writes
//   through a valid/ready handshake. The queue drains one entry per cycle into
//   writeEn/writeAddr/writeData unless wbStall holds the head. Two
//   combinational forwarding lookups let operand reads see values that are
//   still queued. Writes to x0 are accepted and silently dropped.
//
// Ports:
//   clk          in   1           clock, rising edge
//   reset        in   1           asynchronous, active-low reset
//   inValid      in   1           producer has a write request
//   inReady      out  1           queue can accept (count < Depth)
//   inAddr       in   IndexWidth  destination register
//   inData       in   DataWidth   value to write
//   wbStall      in   1           register file port unavailable, hold head
//   writeEn      out  1           register file write enable
//   writeAddr    out  IndexWidth  register file write address
//   writeData    out  DataWidth   register file write data
//   lookupAddr1  in   IndexWidth  forwarding query 1 (rs1)
//   lookupAddr2  in   IndexWidth  forwarding query 2 (rs2)
//   lookupHit1   out  1           queued write to lookupAddr1 exists
//   lookupHit2   out  1           queued write to lookupAddr2 exists
//   lookupData1  out  DataWidth   youngest queued value for lookupAddr1
//   lookupData2  out  DataWidth   youngest queued value for lookupAddr2
//   count        out  CountWidth  current occupancy
// -----------------------------------------------------------------------------
module writeback_queue #(
    parameter int DataWidth  = 32,
    parameter int NumRegs    = 32,
    parameter int IndexWidth = $clog2(NumRegs),
    parameter int Depth      = 4,
    parameter int CountWidth = $clog2(Depth + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [IndexWidth-1:0] inAddr,
    input  logic [DataWidth-1:0]  inData,
    input  logic                  wbStall,
    output logic                  writeEn,
    output logic [IndexWidth-1:0] writeAddr,
    output logic [DataWidth-1:0]  writeData,
    input  logic [IndexWidth-1:0] lookupAddr1,
    input  logic [IndexWidth-1:0] lookupAddr2,
    output logic                  lookupHit1,
    output logic                  lookupHit2,
    output logic [DataWidth-1:0]  lookupData1,
    output logic [DataWidth-1:0]  lookupData2,
    output logic [CountWidth-1:0] count
);

    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CountWidth-1:0] DepthCount = CountWidth'(Depth);
    localparam logic [CountWidth-1:0] CountZero  = {CountWidth{1'b0}};
    localparam logic [CountWidth-1:0] CountOne   = {{(CountWidth-1){1'b0}}, 1'b1};
    localparam logic [PtrWidth-1:0]   PtrOne     = {{(PtrWidth-1){1'b0}}, 1'b1};
    localparam logic [IndexWidth-1:0] AddrZero   = {IndexWidth{1'b0}};
    localparam logic [DataWidth-1:0]  DataZero   = {DataWidth{1'b0}};

    // Entry storage; r_valid marks live slots so lookups ignore stale contents.
    logic [IndexWidth-1:0] r_addr [Depth];
    logic [DataWidth-1:0]  r_data [Depth];
    logic [Depth-1:0]      r_valid;
    logic [PtrWidth-1:0]   r_head;
    logic [PtrWidth-1:0]   r_tail;
    logic [CountWidth-1:0] r_count;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [DataWidth:0]    w_look1;
    logic [DataWidth:0]    w_look2;

    // Youngest-match search. Slots are walked from head (oldest) towards tail,
    // so a later match overwrites an earlier one and the youngest value wins.
    // Register 0 never hits: it is architecturally hard-wired to zero.
    function automatic logic [DataWidth:0] f_lookup(
        input logic [IndexWidth-1:0] query,
        input logic [PtrWidth-1:0]   head,
        input logic [Depth-1:0]      valid,
        input logic [IndexWidth-1:0] addrs [Depth],
        input logic [DataWidth-1:0]  datas [Depth]
    );
        logic                 hit;
        logic [DataWidth-1:0] data;
        logic [PtrWidth-1:0]  idx;
        hit  = 1'b0;
        data = DataZero;
        for (int i = 0; i < Depth; i++) begin
            idx = head + PtrWidth'(i);
            if (valid[idx] && (addrs[idx] == query)) begin
                hit  = 1'b1;
                data = datas[idx];
            end else begin
                hit  = hit;
                data = data;
            end
        end
        if (query == AddrZero) begin
            hit  = 1'b0;
            data = DataZero;
        end else begin
            hit  = hit;
            data = data;
        end
        return {hit, data};
    endfunction

    // Handshake decode: an x0 write completes the handshake but allocates nothing.
    always_comb begin
        w_accept = inValid && (r_count < DepthCount);
        w_push   = w_accept && (inAddr != AddrZero);
        w_pop    = (r_count != CountZero) && !wbStall;
    end

    // Pointers, occupancy and valid bits; reset discards everything queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= {PtrWidth{1'b0}};
            r_tail  <= {PtrWidth{1'b0}};
            r_count <= CountZero;
            r_valid <= {Depth{1'b0}};
        end else begin
            if (w_push) begin
                r_tail          <= r_tail + PtrOne;
                r_valid[r_tail] <= 1'b1;
            end
            // Push and pop never target the same slot: a push with a pop
            // implies 0 < count < Depth, so head != tail.
            if (w_pop) begin
                r_head          <= r_head + PtrOne;
                r_valid[r_head] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CountOne;
                2'b01:   r_count <= r_count - CountOne;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload capture at the tail slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                r_addr[i] <= AddrZero;
                r_data[i] <= DataZero;
            end
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= inAddr;
                r_data[r_tail] <= inData;
            end
        end
    end

    // Drain port and ready; outputs are forced to zero when nothing drains.
    always_comb begin
        inReady = (r_count < DepthCount);
        count   = r_count;
        if (w_pop) begin
            writeEn   = 1'b1;
            writeAddr = r_addr[r_head];
            writeData = r_data[r_head];
        end else begin
            writeEn   = 1'b0;
            writeAddr = AddrZero;
            writeData = DataZero;
        end
    end

    // Forwarding lookups; the in-flight inValid request is deliberately not searched.
    always_comb begin
        w_look1     = f_lookup(lookupAddr1, r_head, r_valid, r_addr, r_data);
        w_look2     = f_lookup(lookupAddr2, r_head, r_valid, r_addr, r_data);
        lookupHit1  = w_look1[DataWidth];
        lookupData1 = w_look1[DataWidth-1:0];
        lookupHit2  = w_look2[DataWidth];
        lookupData2 = w_look2[DataWidth-1:0];
    end

endmodule

// File: tb/tb_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_writeback_queue
//
// Directed bench for writeback_queue (DataWidth 32, 32 registers, Depth 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled a further
// time unit later, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_writeback_queue;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [4:0]  inAddr;
    logic [31:0] inData;
    logic        wbStall;
    logic        writeEn;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic [4:0]  lookupAddr1;
    logic [4:0]  lookupAddr2;
    logic        lookupHit1;
    logic        lookupHit2;
    logic [31:0] lookupData1;
    logic [31:0] lookupData2;
    logic [2:0]  count;

    int n_checks;
    int n_errors;

    writeback_queue #(
        .DataWidth (32),
        .NumRegs   (32),
        .Depth     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inValid     (inValid),
        .inReady     (inReady),
        .inAddr      (inAddr),
        .inData      (inData),
        .wbStall     (wbStall),
        .writeEn     (writeEn),
        .writeAddr   (writeAddr),
        .writeData   (writeData),
        .lookupAddr1 (lookupAddr1),
        .lookupAddr2 (lookupAddr2),
        .lookupHit1  (lookupHit1),
        .lookupHit2  (lookupHit2),
        .lookupData1 (lookupData1),
        .lookupData2 (lookupData2),
        .count       (count)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        inValid     = 1'b0;
        inAddr      = 5'd0;
        inData      = 32'h0;
        wbStall     = 1'b0;
        lookupAddr1 = 5'd0;
        lookupAddr2 = 5'd0;

        // 1: asynchronous reset at t=5, hold state after release
        #5 reset = 1'b0;
        #1;
        check("rst_count",   32'(count),      32'd0);
        check("rst_inReady", 32'(inReady),    32'd1);
        check("rst_writeEn", 32'(writeEn),    32'd0);
        check("rst_wAddr",   32'(writeAddr),  32'd0);
        check("rst_wData",   writeData,       32'h0);
        check("rst_hit1",    32'(lookupHit1), 32'd0);
        check("rst_hit2",    32'(lookupHit2), 32'd0);
        check("rst_data1",   lookupData1,     32'h0);
        tick();
        reset = 1'b1;
        settle();
        check("rel_count",   32'(count),   32'd0);
        check("rel_writeEn", 32'(writeEn), 32'd0);

        // 2: single push, drains one cycle later, no same-cycle bypass
        inValid = 1'b1;
        inAddr  = 5'd5;
        inData  = 32'h1234_5678;
        settle();
        check("t2_no_bypass", 32'(writeEn), 32'd0);
        tick();
        inValid = 1'b0;
        settle();
        check("t2_writeEn", 32'(writeEn),   32'd1);
        check("t2_wAddr",   32'(writeAddr), 32'd5);
        check("t2_wData",   writeData,      32'h1234_5678);
        check("t2_count",   32'(count),     32'd1);
        tick();
        check("t2_count_after", 32'(count),   32'd0);
        check("t2_idle",        32'(writeEn), 32'd0);

        // 3: fill under stall, reject when full, drain in order
        wbStall = 1'b1;
        for (int a = 1; a <= 4; a++) begin
            inValid = 1'b1;
            inAddr  = 5'(a);
            inData  = 32'(a * 32'h11);
            tick();
        end
        inValid = 1'b0;
        settle();
        check("t3_full_count",   32'(count),   32'd4);
        check("t3_full_inReady", 32'(inReady), 32'd0);
        check("t3_stalled",      32'(writeEn), 32'd0);
        inValid = 1'b1;
        inAddr  = 5'd9;
        inData  = 32'h99;
        settle();
        check("t3_push5_ready", 32'(inReady), 32'd0);
        tick();
        inValid = 1'b0;
        settle();
        check("t3_push5_count", 32'(count), 32'd4);
        wbStall = 1'b0;
        settle();
        check("t3_pop1_en",    32'(writeEn),   32'd1);
        check("t3_pop1_addr",  32'(writeAddr), 32'd1);
        check("t3_pop1_data",  writeData,      32'h11);
        check("t3_pop1_ready", 32'(inReady),   32'd0);
        tick();
        check("t3_pop2_addr",  32'(writeAddr), 32'd2);
        check("t3_pop2_data",  writeData,      32'h22);
        check("t3_pop2_ready", 32'(inReady),   32'd1);
        check("t3_pop2_count", 32'(count),     32'd3);
        tick();
        check("t3_pop3_addr", 32'(writeAddr), 32'd3);
        tick();
        check("t3_pop4_addr", 32'(writeAddr), 32'd4);
        check("t3_pop4_data", writeData,      32'h44);
        tick();
        check("t3_done_en",    32'(writeEn), 32'd0);
        check("t3_done_count", 32'(count),   32'd0);

        // 4: youngest match wins, miss reads zero
        wbStall = 1'b1;
        inValid = 1'b1;
        inAddr  = 5'd7;
        inData  = 32'hAAAA;
        tick();
        inData  = 32'hBBBB;
        tick();
        inValid     = 1'b0;
        lookupAddr1 = 5'd7;
        lookupAddr2 = 5'd8;
        settle();
        check("t4_hit1",  32'(lookupHit1), 32'd1);
        check("t4_data1", lookupData1,     32'hBBBB);
        check("t4_hit2",  32'(lookupHit2), 32'd0);
        check("t4_data2", lookupData2,     32'h0);
        check("t4_count", 32'(count),      32'd2);
        wbStall = 1'b0;
        settle();
        check("t4_drain1",       writeData,       32'hAAAA);
        check("t4_drain1_hit1",  lookupData1,     32'hBBBB);
        tick();
        check("t4_drain2",       writeData,       32'hBBBB);
        check("t4_drain2_hit1",  32'(lookupHit1), 32'd1);
        tick();
        check("t4_empty_hit1",   32'(lookupHit1), 32'd0);
        check("t4_empty_en",     32'(writeEn),    32'd0);
        lookupAddr1 = 5'd0;
        lookupAddr2 = 5'd0;

        // 5: write to x0 is accepted and dropped
        inValid = 1'b1;
        inAddr  = 5'd0;
        inData  = 32'hdead_beef;
        settle();
        check("t5_ready", 32'(inReady), 32'd1);
        tick();
        inValid = 1'b0;
        settle();
        check("t5_count", 32'(count),      32'd0);
        check("t5_en",    32'(writeEn),    32'd0);
        check("t5_hit1",  32'(lookupHit1), 32'd0);
        check("t5_data1", lookupData1,     32'h0);

        // 6: reset mid-stream discards queued entries
        wbStall = 1'b1;
        for (int a = 10; a <= 12; a++) begin
            inValid = 1'b1;
            inAddr  = 5'(a);
            inData  = 32'(a) + 32'h100;
            tick();
        end
        inValid     = 1'b0;
        lookupAddr1 = 5'd11;
        settle();
        check("t6_count3",  32'(count),  32'd3);
        check("t6_hit_pre", lookupData1, 32'h10b);
        #2 reset = 1'b0;
        #1;
        check("t6_async_count", 32'(count),      32'd0);
        check("t6_async_hit1",  32'(lookupHit1), 32'd0);
        check("t6_async_ready", 32'(inReady),    32'd1);
        tick();
        reset   = 1'b1;
        wbStall = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            check("t6_no_write", 32'(writeEn), 32'd0);
            tick();
        end
        check("t6_final_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
